// File: rtl/sumator_secvential.sv
// Digit-serial adder: adds two N-bit operands W bits per cycle, LSB digit first.
// Optional macro SUMATOR_SCAD_EN adds the op input for subtraction (i1 + ~i2 + 1).
module sumator_secvential #(
    parameter int N = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] i1,
    input  logic [N-1:0] i2,
    input  logic         cin,
`ifdef SUMATOR_SCAD_EN
    input  logic         op,
`endif
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int D  = N / W;
    localparam int CW = (D > 1) ? $clog2(D) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;
    logic [N-1:0]  acc_r;
    logic [N-1:0]  sum_r;
    logic [CW-1:0] cnt_r;
    logic          carry_r;
    logic          cmsb_r;
    logic          busy_r;
    logic          done_r;
    logic          cout_r;
    logic          ovf_r;

    logic [N-1:0]  bsel_s;
    logic          csel_s;
    logic [W-1:0]  da_s;
    logic [W-1:0]  db_s;
    logic [W-1:0]  ds_s;
    logic          dc_s;
    logic          last_s;

    function automatic logic [W:0] digit_add(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic         c);
        digit_add = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

`ifdef SUMATOR_SCAD_EN
    // Subtraction is folded into the latched operand: invert i2, force carry-in to 1
    always_comb begin
        if (op) begin
            bsel_s = ~i2;
            csel_s = 1'b1;
        end else begin
            bsel_s = i2;
            csel_s = cin;
        end
    end
`else
    // Add-only build: operands pass straight through
    always_comb begin
        bsel_s = i2;
        csel_s = cin;
    end
`endif

    // Current digit slice and its sum with the running carry
    always_comb begin
        da_s         = a_r[int'(cnt_r) * W +: W];
        db_s         = b_r[int'(cnt_r) * W +: W];
        {dc_s, ds_s} = digit_add(da_s, db_s, carry_r);
        last_s       = (cnt_r == CW'(D - 1));
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = ADD;
                else       state_s = IDLE;
            end
            ADD: begin
                if (last_s) state_s = DONE;
                else        state_s = ADD;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r     <= {N{1'b0}};
            b_r     <= {N{1'b0}};
            acc_r   <= {N{1'b0}};
            cnt_r   <= {CW{1'b0}};
            carry_r <= 1'b0;
            cmsb_r  <= 1'b0;
            sum_r   <= {N{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            busy_r <= (state_r == ADD);
            done_r <= (state_r == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r     <= i1;
                        b_r     <= bsel_s;
                        carry_r <= csel_s;
                        acc_r   <= {N{1'b0}};
                        cnt_r   <= {CW{1'b0}};
                        cmsb_r  <= 1'b0;
                    end
                end
                ADD: begin
                    acc_r[int'(cnt_r) * W +: W] <= ds_s;
                    carry_r <= dc_s;
                    // carry into the digit MSB; only the top digit's value survives
                    cmsb_r  <= ds_s[W-1] ^ da_s[W-1] ^ db_s[W-1];
                    cnt_r   <= cnt_r + CW'(1'b1);
                end
                DONE: begin
                    sum_r  <= acc_r;
                    cout_r <= carry_r;
                    ovf_r  <= carry_r ^ cmsb_r;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_sumator_secvential.sv
// Scoreboard bench for sumator_secvential: three configurations (N/W = 4/2, 4/4, 8/2)
// share stimulus; expected results come from plain integer arithmetic.
module tb_sumator_secvential;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       cin;
    logic       op;
    logic [7:0] a;
    logic [7:0] b;

    logic       busy0, done0, cout0, ovf0;
    logic       busy1, done1, cout1, ovf1;
    logic       busy2, done2, cout2, ovf2;
    logic [3:0] sum0, sum1;
    logic [7:0] sum2;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         start_c;
    } exp_t;

    exp_t q[3][$];
    int   nn[3] = '{4, 4, 8};
    int   dd[3] = '{2, 1, 4};
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   chk_busy = 1'b1;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sumator_secvential #(.N(4), .W(2)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .i1(a[3:0]), .i2(b[3:0]), .cin(cin),
`ifdef SUMATOR_SCAD_EN
        .op(op),
`endif
        .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0));

    sumator_secvential #(.N(4), .W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .i1(a[3:0]), .i2(b[3:0]), .cin(cin),
`ifdef SUMATOR_SCAD_EN
        .op(op),
`endif
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));

    sumator_secvential #(.N(8), .W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .i1(a), .i2(b), .cin(cin),
`ifdef SUMATOR_SCAD_EN
        .op(op),
`endif
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));

    // Reference: whole-word integer add, signs compared for overflow
    function automatic exp_t model(int n, logic [7:0] x, logic [7:0] y, logic c, logic o, int sc);
        exp_t e;
        int mask = (1 << n) - 1;
        int xa = int'(x) & mask;
        int yb = (o ? int'(~y) : int'(y)) & mask;
        int ci = o ? 1 : int'(c);
        int full = xa + yb + ci;
        int s = full & mask;
        int sa = (xa >> (n - 1)) & 1;
        int sb = (yb >> (n - 1)) & 1;
        int ss = (s >> (n - 1)) & 1;
        e.sum = 8'(s);
        e.cout = ((full >> n) & 1) == 1;
        e.ovf = (sa == sb) && (ss != sa);
        e.start_c = sc;
        return e;
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon(int k, logic bz, logic dn, logic [7:0] s, logic co, logic ov);
        exp_t e;
        int eb;
        if (dn) begin
            if (q[k].size() == 0) begin
                chk($sformatf("u%0d_spurious_done", k), 1, 0);
            end else begin
                e = q[k].pop_front();
                chk($sformatf("u%0d_latency", k), cyc, e.start_c + dd[k] + 1);
                chk($sformatf("u%0d_sum", k), int'(s), int'(e.sum));
                chk($sformatf("u%0d_cout", k), int'(co), int'(e.cout));
                chk($sformatf("u%0d_ovf", k), int'(ov), int'(e.ovf));
            end
        end
        if (chk_busy) begin
            eb = 0;
            if (q[k].size() > 0)
                eb = (cyc >= q[k][0].start_c + 1 && cyc <= q[k][0].start_c + dd[k]) ? 1 : 0;
            chk($sformatf("u%0d_busy", k), int'(bz), eb);
        end
    endtask

    // Monitor: compare every presented result against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, busy0, done0, {4'b0, sum0}, cout0, ovf0);
            mon(1, busy1, done1, {4'b0, sum1}, cout1, ovf1);
            mon(2, busy2, done2, sum2, cout2, ovf2);
        end
    end

    // Drive one start (held for hold+1 edges); push an expectation per restart
    task automatic issue(logic [7:0] x, logic [7:0] y, logic c, logic o, bit push, int hold);
        @(negedge clk);
        a = x; b = y; cin = c; op = o; start = 1'b1;
        for (int h = 0; h <= hold; h++) begin
            @(posedge clk);
            #1;
            if (push)
                for (int k = 0; k < 3; k++)
                    if (h % (dd[k] + 2) == 0)
                        q[k].push_back(model(nn[k], x, y, c, o, cyc));
        end
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending %0d expected 0", q[0].size() + q[1].size() + q[2].size());
            for (int k = 0; k < 3; k++) q[k].delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: cycle %0d expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx, ry;
        logic rc, ro;
        rst_n = 1'b0; start = 1'b1; cin = 1'b1; op = 1'b0; a = 8'hFF; b = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done2), 0);
        chk("rst_sum", int'(sum2), 0);
        chk("rst_cout", int'(cout0), 0);
        chk("rst_ovf", int'(ovf1), 0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        issue(8'd12, 8'd14, 1'b0, 1'b0, 1'b1, 0); drain();
        chk("d12p14_sum", int'(sum0), 10); chk("d12p14_cout", int'(cout0), 1); chk("d12p14_ovf", int'(ovf0), 0);
        issue(8'd10, 8'd9, 1'b0, 1'b0, 1'b1, 0); drain();
        chk("d10p9_sum", int'(sum0), 3); chk("d10p9_cout", int'(cout0), 1); chk("d10p9_ovf", int'(ovf0), 1);
        issue(8'd7, 8'd1, 1'b0, 1'b0, 1'b1, 0); drain();
        chk("d7p1_sum", int'(sum1), 8); chk("d7p1_cout", int'(cout1), 0); chk("d7p1_ovf", int'(ovf1), 1);
        issue(8'd8, 8'd6, 1'b1, 1'b0, 1'b1, 0); drain();
        chk("d8p6c_sum", int'(sum1), 15); chk("d8p6c_cout", int'(cout1), 0); chk("d8p6c_ovf", int'(ovf1), 0);

        // start re-pulsed with new operands while every instance is busy
        issue(8'd3, 8'd4, 1'b0, 1'b0, 1'b1, 0);
        a = 8'hF0; b = 8'hEE; cin = 1'b1; start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        chk("ign_sum0", int'(sum0), 7); chk("ign_sum2", int'(sum2), 7);

        // reset for one cycle mid-ADD, with start asserted during it
        chk_busy = 1'b0;
        issue(8'd5, 8'd6, 1'b0, 1'b0, 1'b0, 0);
        rst_n = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1; start = 1'b0; chk_busy = 1'b1;
        chk("abort_busy0", int'(busy0), 0); chk("abort_busy2", int'(busy2), 0);
        chk("abort_sum0", int'(sum0), 0); chk("abort_sum2", int'(sum2), 0);
        repeat (8) @(posedge clk);
        issue(8'd2, 8'd9, 1'b1, 1'b0, 1'b1, 0); drain();
        chk("post_rst_sum0", int'(sum0), 12);

        // start held high: back-to-back operations
        issue(8'd9, 8'd5, 1'b1, 1'b0, 1'b1, 12); drain();

`ifdef SUMATOR_SCAD_EN
        issue(8'd3, 8'd5, 1'b0, 1'b1, 1'b1, 0); drain();
        chk("sub3m5_sum", int'(sum0), 14); chk("sub3m5_cout", int'(cout0), 0);
        issue(8'd5, 8'd3, 1'b1, 1'b1, 1'b1, 0); drain();
        chk("sub5m3_sum", int'(sum0), 2); chk("sub5m3_cout", int'(cout0), 1);
`endif

        for (int i = 0; i < 40; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rc = 1'($urandom);
`ifdef SUMATOR_SCAD_EN
            ro = 1'($urandom);
`else
            ro = 1'b0;
`endif
            issue(rx, ry, rc, ro, 1'b1, ($urandom_range(0, 3) == 0) ? 6 : 0);
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
